// File: rtl/frame_pacer_if.sv
// Decoder frame-done handshake: decoder raises frame_valid, pacer answers with a frame_ack pulse.
interface frame_pacer_if;
    logic frame_valid;
    logic frame_ack;

    modport master (output frame_valid, input frame_ack);
    modport slave  (input frame_valid, output frame_ack);
endinterface

// File: rtl/frame_pacer.sv
// Releases decoded frames at the configured cadence, with single-step while paused
// and a saturating count of periods that expired before a frame was ready.
module frame_pacer #(
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned FCNT_W = 16,
    parameter int unsigned LATE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CNT_W-1:0]    num_cycles_1_frame,
    input  logic                step_req,
    frame_pacer_if.slave        frm,
    output logic                paused,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic [LATE_W-1:0]   late_frames
);

    typedef enum logic [1:0] {S_PAUSE, S_COUNT, S_WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             step_pend, step_pend_nxt;
    logic             ack_nxt;
    logic             late_inc;
    logic             fv;
    logic             period_zero;
    logic             expired;

    // A frame presented during the ack cycle belongs to the frame just released.
    assign fv          = frm.frame_valid & ~frm.frame_ack;
    assign period_zero = (num_cycles_1_frame == '0);
    assign expired     = !period_zero && (cnt >= num_cycles_1_frame - CNT_W'(1));
    assign paused      = (state == S_PAUSE);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        step_pend_nxt = step_pend;
        ack_nxt       = 1'b0;
        late_inc      = 1'b0;
        case (state)
            S_PAUSE: begin
                cnt_nxt = '0;
                if (!period_zero) begin
                    state_nxt     = S_COUNT;
                    step_pend_nxt = 1'b0;
                end else begin
                    if (step_pend && fv) begin
                        ack_nxt       = 1'b1;
                        step_pend_nxt = 1'b0;
                    end
                    if (step_req) begin
                        step_pend_nxt = 1'b1;
                    end
                end
            end
            S_COUNT: begin
                if (period_zero) begin
                    state_nxt = S_PAUSE;
                    cnt_nxt   = '0;
                end else if (expired) begin
                    cnt_nxt = '0;
                    if (fv) begin
                        ack_nxt = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        late_inc  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                cnt_nxt = '0;
                if (period_zero) begin
                    state_nxt = S_PAUSE;
                end else if (fv) begin
                    ack_nxt   = 1'b1;
                    state_nxt = S_COUNT;
                end
            end
            default: begin
                state_nxt = S_PAUSE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_PAUSE;
            cnt           <= '0;
            step_pend     <= 1'b0;
            frm.frame_ack <= 1'b0;
            frame_cnt     <= '0;
            late_frames   <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            step_pend     <= step_pend_nxt;
            frm.frame_ack <= ack_nxt;
            if (ack_nxt) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
            if (late_inc && (late_frames != '1)) begin
                late_frames <= late_frames + LATE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_pacer.sv
// Directed bench for frame_pacer: a cycle model checked every cycle plus literal checkpoints.
module tb_frame_pacer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] period = '0;
    logic        step_req = 1'b0;
    logic        valid = 1'b0;
    logic        chk_en = 1'b0;
    longint      cyc = 0;

    int total = 0;
    int bad   = 0;

    frame_pacer_if if_m();
    frame_pacer_if if_s();
    assign if_m.frame_valid = valid;
    assign if_s.frame_valid = valid;

    logic        paused_m, paused_s;
    logic [15:0] fcnt_m, fcnt_s, late_m;
    logic [5:0]  late_s;

    frame_pacer u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .num_cycles_1_frame (period),
        .step_req           (step_req),
        .frm                (if_m.slave),
        .paused             (paused_m),
        .frame_cnt          (fcnt_m),
        .late_frames        (late_m)
    );

    // Narrow late counter so saturation is reachable in a short run.
    frame_pacer #(.LATE_W(6)) u_sat (
        .clk                (clk),
        .rst_n              (rst_n),
        .num_cycles_1_frame (period),
        .step_req           (step_req),
        .frm                (if_s.slave),
        .paused             (paused_s),
        .frame_cnt          (fcnt_s),
        .late_frames        (late_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: mode 0 = paused, 1 = timing a period, 2 = period over, waiting for a frame.
    typedef struct {
        int          mode;
        int unsigned el;
        bit          pend;
        bit          ack;
        int unsigned fcnt;
        int unsigned late;
    } model_t;

    model_t m = '{default: 0};

    function automatic model_t model_step(model_t s, int unsigned per, bit step, bit v);
        model_t n;
        bit     ready;
        n     = s;
        n.ack = 1'b0;
        ready = v && !s.ack;
        case (s.mode)
            0: begin
                n.el = 0;
                if (per != 0) begin
                    n.mode = 1;
                    n.pend = 1'b0;
                end else begin
                    if (s.pend && ready) begin
                        n.ack  = 1'b1;
                        n.pend = 1'b0;
                    end
                    if (step) n.pend = 1'b1;
                end
            end
            1: begin
                if (per == 0) begin
                    n.mode = 0;
                    n.el   = 0;
                end else if (s.el + 1 >= per) begin
                    n.el = 0;
                    if (ready) n.ack = 1'b1;
                    else begin
                        n.mode = 2;
                        n.late = s.late + 1;
                    end
                end else begin
                    n.el = s.el + 1;
                end
            end
            default: begin
                n.el = 0;
                if (per == 0) n.mode = 0;
                else if (ready) begin
                    n.ack  = 1'b1;
                    n.mode = 1;
                end
            end
        endcase
        if (n.ack) n.fcnt = (s.fcnt + 1) % 65536;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= model_step(m, period, step_req, valid);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack",        {31'd0, if_m.frame_ack}, {31'd0, m.ack});
            check("paused",     {31'd0, paused_m},       (m.mode == 0) ? 32'd1 : 32'd0);
            check("frame_cnt",  {16'd0, fcnt_m},         m.fcnt);
            check("late",       {16'd0, late_m},         (m.late > 65535) ? 32'd65535 : m.late);
            check("sat_ack",    {31'd0, if_s.frame_ack}, {31'd0, m.ack});
            check("sat_fcnt",   {16'd0, fcnt_s},         m.fcnt);
            check("sat_late",   {26'd0, late_s},         (m.late > 63) ? 32'd63 : m.late);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input int max, input string name, output longint at);
        logic found;
        found = 1'b0;
        at    = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (if_m.frame_ack === 1'b1) begin
                found = 1'b1;
                at    = cyc;
                break;
            end
        end
        if (!found) check(name, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        longint a, prev, s;

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ack",    {31'd0, if_m.frame_ack}, 32'd0);
        check("rst_paused", {31'd0, paused_m},       32'd1);
        check("rst_fcnt",   {16'd0, fcnt_m},         32'd0);
        check("rst_late",   {16'd0, late_m},         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Steady play, period 4
        valid  = 1'b1;
        period = 24'd4;
        wait_ack(20, "t1_first_timeout", a);
        prev = a;
        for (int k = 1; k < 5; k++) begin
            wait_ack(10, "t1_timeout", a);
            check("t1_spacing", 32'(a - prev), 32'd4);
            prev = a;
        end
        check("t1_fcnt", {16'd0, fcnt_m}, 32'd5);

        // Late frame: decoder misses the deadline by 10 cycles
        valid = 1'b0;
        tick(14);
        check("t2_late",   {16'd0, late_m},   32'd1);
        check("t2_paused", {31'd0, paused_m}, 32'd0);
        valid = 1'b1;
        @(negedge clk);
        check("t2_late_ack", {31'd0, if_m.frame_ack}, 32'd1);
        check("t2_fcnt",     {16'd0, fcnt_m},         32'd6);
        prev = cyc;
        wait_ack(10, "t2_timeout", a);
        check("t2_restart_spacing", 32'(a - prev), 32'd4);

        // Period shrinks mid-count
        period = 24'd100;
        tick(50);
        period = 24'd5;
        @(negedge clk);
        check("t4_shrink_ack", {31'd0, if_m.frame_ack}, 32'd1);
        prev = cyc;
        wait_ack(10, "t4_timeout", a);
        check("t4_spacing", 32'(a - prev), 32'd5);

        // Pause and single-step
        period = 24'd0;
        tick(5);
        check("t3_paused",     {31'd0, paused_m}, 32'd1);
        check("t3_no_release", {16'd0, fcnt_m},   32'd9);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        @(negedge clk);
        check("t3_step_ack", {31'd0, if_m.frame_ack}, 32'd1);
        tick(5);
        check("t3_one_step", {16'd0, fcnt_m}, 32'd10);
        valid    = 1'b0;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        tick(4);
        check("t3_step_waits", {16'd0, fcnt_m}, 32'd10);
        valid = 1'b1;
        @(negedge clk);
        check("t3_step_late_ack", {31'd0, if_m.frame_ack}, 32'd1);
        check("t3_fcnt",          {16'd0, fcnt_m},         32'd11);

        // Step coinciding with play: play wins
        tick(2);
        s        = cyc;
        step_req = 1'b1;
        period   = 24'd4;
        @(negedge clk);
        step_req = 1'b0;
        @(negedge clk);
        check("t3_play_wins", {31'd0, if_m.frame_ack}, 32'd0);
        wait_ack(10, "t3_play_timeout", a);
        check("t3_play_first", 32'(a - s), 32'd5);

        // Period 1: ack mask forces every other cycle
        period = 24'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_alternate", {31'd0, if_m.frame_ack}, 32'(i % 2));
        end
        check("t6_late", {16'd0, late_m}, 32'd6);
        tick(130);
        check("t6_sat_late",  {26'd0, late_s}, 32'd63);
        check("t6_main_late", {16'd0, late_m}, 32'd71);
        check("t6_fcnt",      {16'd0, fcnt_m}, 32'd82);

        // Asynchronous reset while waiting for a late frame
        period = 24'd4;
        valid  = 1'b0;
        tick(10);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        check("t5_in_wait", {31'd0, paused_m}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_ack",    {31'd0, if_m.frame_ack}, 32'd0);
        check("t5_rst_paused", {31'd0, paused_m},       32'd1);
        check("t5_rst_fcnt",   {16'd0, fcnt_m},         32'd0);
        check("t5_rst_late",   {16'd0, late_m},         32'd0);
        check("t5_rst_late_s", {26'd0, late_s},         32'd0);
        period = 24'd0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("t5_paused_after", {31'd0, paused_m}, 32'd1);
        check("t5_fcnt_after",   {16'd0, fcnt_m},   32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
